// File: rtl/aap_fetch_stage.sv
// Instruction fetch stage: drives the PC into a synchronous instruction memory and
// queues returned words for the decoder behind a valid/ready handshake.
module aap_fetch_stage #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 2
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              enable,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              fetch_valid,
   input  logic              fetch_ready,
   output logic [15:0]       fetchoutput,
   output logic [ADDR_W-1:0] fetch_pc
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_REDIR = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q;
   logic              inflight_q;
   logic [ADDR_W-1:0] inflight_pc_q;
   logic [CNT_W-1:0]  count_q;
   logic [15:0]       q_data [DEPTH];
   logic [ADDR_W-1:0] q_pc   [DEPTH];

   logic              flush, push, pop, issue;
   logic [CNT_W:0]    occ;
   logic [IDX_W-1:0]  wr_idx;

   always_comb begin
      flush   = redirect_valid && (state_q != S_IDLE);
      pop     = fetch_valid && fetch_ready && !flush;
      push    = inflight_q && !flush;
      // occupancy after this cycle's return and pop; a new issue needs a free slot
      occ     = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
      issue   = (state_q == S_RUN) && enable && !redirect_valid
                && (occ < (CNT_W+1)'(DEPTH));
      wr_idx  = IDX_W'(count_q - {{(CNT_W-1){1'b0}}, pop});
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!redirect_valid && enable) state_d = S_RUN;
         S_RUN:   if (redirect_valid) state_d = S_REDIR;
         S_REDIR: if (!redirect_valid) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req    = issue;
   assign imem_addr   = pc_q;
   assign fetch_valid = (count_q != '0);
   assign fetchoutput = q_data[0];
   assign fetch_pc    = q_pc[0];

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         count_q       <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         if (issue) inflight_pc_q <= pc_q;
         if (redirect_valid)
            pc_q <= redirect_pc;
         else if (issue)
            pc_q <= pc_q + 1'b1;
         if (flush)
            count_q <= '0;
         else if (push && !pop)
            count_q <= count_q + CNT_W'(1);
         else if (pop && !push)
            count_q <= count_q - CNT_W'(1);
      end
   end

   // Head always sits in entry 0 so the decoder sees plain registers.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
            q_data[IDX_W'(i)] <= '0;
            q_pc[IDX_W'(i)]   <= '0;
         end
      end else begin
         if (pop) begin
            for (int unsigned i = 0; i + 1 < unsigned'(DEPTH); i++) begin
               q_data[IDX_W'(i)] <= q_data[IDX_W'(i + 1)];
               q_pc[IDX_W'(i)]   <= q_pc[IDX_W'(i + 1)];
            end
         end
         if (push) begin
            q_data[wr_idx] <= imem_rdata;
            q_pc[wr_idx]   <= inflight_pc_q;
         end
      end
   end

endmodule

// File: tb/tb_aap_fetch_stage.sv
// Scoreboard bench for aap_fetch_stage: expected PC stream is queued by the stimulus
// (reset/redirect targets), a monitor pops and compares every accepted word.
module tb_aap_fetch_stage;

   localparam int ADDR_W = 16;
   localparam int DEPTH  = 2;

   logic              CLOCK_50 = 1'b0;
   logic              reset;
   logic              enable, fetch_ready, redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              imem_req, fetch_valid;
   logic [ADDR_W-1:0] imem_addr, fetch_pc;
   logic [15:0]       imem_rdata, fetchoutput;

   logic              w_enable = 1'b1, w_ready = 1'b1, w_redirect = 1'b0;
   logic [ADDR_W-1:0] w_redirect_pc = '0;
   logic              w_imem_req, w_fetch_valid;
   logic [ADDR_W-1:0] w_imem_addr, w_fetch_pc;
   logic [15:0]       w_imem_rdata, w_fetchoutput;

   int checks = 0;
   int errors = 0;
   int handshakes = 0;
   int wseen = 0;
   logic [15:0] exp_q[$];

   always #5 CLOCK_50 = ~CLOCK_50;

   aap_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .fetchoutput(fetchoutput), .fetch_pc(fetch_pc)
   );

   aap_fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(16'hFFFE), .DEPTH(DEPTH)) u_wrap (
      .CLOCK_50(CLOCK_50), .reset(reset), .enable(w_enable),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
      .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
      .fetch_valid(w_fetch_valid), .fetch_ready(w_ready),
      .fetchoutput(w_fetchoutput), .fetch_pc(w_fetch_pc)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a + 16'hA000;
   endfunction

   // Synchronous memories; garbage on idle cycles so stray captures show up.
   always @(posedge CLOCK_50) begin
      imem_rdata   <= imem_req   ? mem_word(imem_addr)   : 16'($urandom);
      w_imem_rdata <= w_imem_req ? mem_word(w_imem_addr) : 16'($urandom);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_exp(input logic [15:0] pc);
      exp_q.delete();
      exp_q.push_back(pc);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_imem_req"},    imem_req,    1'b0);
      chk({tag, "_imem_addr"},   imem_addr,   16'h0000);
      chk({tag, "_fetch_valid"}, fetch_valid, 1'b0);
      chk({tag, "_fetchoutput"}, fetchoutput, 16'h0000);
      chk({tag, "_fetch_pc"},    fetch_pc,    16'h0000);
      chk({tag, "_wrap_addr"},   w_imem_addr, 16'hFFFE);
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Monitor: accepted words against the expected stream, plus hold stability.
   initial begin
      logic        hold;
      logic [15:0] hold_word, hold_pc, pc_e;
      hold = 1'b0;
      hold_word = '0;
      hold_pc = '0;
      forever begin
         @(negedge CLOCK_50);
         if (!reset) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               chk("hold_valid", fetch_valid, 1'b1);
               chk("hold_word", fetchoutput, hold_word);
               chk("hold_pc", fetch_pc, hold_pc);
            end
            hold = 1'b0;
            if (!redirect_valid && fetch_valid && fetch_ready) begin
               handshakes++;
               if (exp_q.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL unexpected_word: got pc %h expected no word", fetch_pc);
               end else begin
                  pc_e = exp_q.pop_front();
                  chk("word_pc", fetch_pc, pc_e);
                  chk("word_data", fetchoutput, mem_word(pc_e));
                  while (exp_q.size() < 4)
                     exp_q.push_back((exp_q.size() == 0) ? pc_e + 16'd1 : exp_q[$] + 16'd1);
               end
            end else if (!redirect_valid && fetch_valid && !fetch_ready) begin
               hold      = 1'b1;
               hold_word = fetchoutput;
               hold_pc   = fetch_pc;
            end
         end
      end
   end

   // Wrap instance: first four deliveries after reset release.
   initial begin
      logic [15:0] wexp [4];
      wexp[0] = 16'hFFFE;
      wexp[1] = 16'hFFFF;
      wexp[2] = 16'h0000;
      wexp[3] = 16'h0001;
      forever begin
         @(negedge CLOCK_50);
         if (reset && w_fetch_valid && wseen < 4) begin
            chk("wrap_pc", w_fetch_pc, wexp[wseen]);
            chk("wrap_word", w_fetchoutput, mem_word(wexp[wseen]));
            wseen++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      int lat, n;
      reset = 1'b0;
      enable = 1'b0;
      fetch_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      repeat (3) tick();
      chk_reset_outputs("rst");

      // release: IDLE->RUN, issue, return, push => valid after 3 edges
      reset = 1'b1;
      enable = 1'b1;
      fetch_ready = 1'b1;
      set_exp(16'h0000);
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (fetch_valid && lat == 0) lat = k;
      end
      chk("first_valid_latency", lat, 3);

      // stall: credit fills, requests stop, then drain exactly DEPTH words
      fetch_ready = 1'b0;
      repeat (10) tick();
      chk("stall_imem_req", imem_req, 1'b0);
      chk("stall_valid", fetch_valid, 1'b1);
      enable = 1'b0;
      fetch_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (fetch_valid) n++;
         tick();
      end
      chk("stall_drain_count", n, DEPTH);
      enable = 1'b1;
      repeat (6) tick();

      // redirect while streaming with a read in flight
      redirect_valid = 1'b1;
      redirect_pc = 16'h0040;
      set_exp(16'h0040);
      tick();
      redirect_valid = 1'b0;
      repeat (8) tick();

      // redirect while the FIFO is full
      fetch_ready = 1'b0;
      repeat (5) tick();
      redirect_valid = 1'b1;
      redirect_pc = 16'h0040;
      set_exp(16'h0040);
      tick();
      redirect_valid = 1'b0;
      fetch_ready = 1'b1;
      repeat (8) tick();

      // back-to-back redirects
      redirect_valid = 1'b1;
      redirect_pc = 16'h0010;
      set_exp(16'h0010);
      tick();
      redirect_pc = 16'h0020;
      set_exp(16'h0020);
      tick();
      redirect_valid = 1'b0;
      for (int k = 0; k < 10 && !fetch_valid; k++) tick();
      chk("b2b_valid", fetch_valid, 1'b1);
      chk("b2b_first_pc", fetch_pc, 16'h0020);
      repeat (6) tick();

      // random traffic
      for (int k = 0; k < 600; k++) begin
         enable = ($urandom_range(0, 9) < 8);
         fetch_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc = 16'($urandom);
            set_exp(redirect_pc);
         end else begin
            redirect_valid = 1'b0;
         end
         tick();
      end
      redirect_valid = 1'b0;

      // asynchronous reset mid-stream
      enable = 1'b1;
      fetch_ready = 1'b1;
      repeat (5) tick();
      #2;
      reset = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      exp_q.delete();
      repeat (2) tick();
      reset = 1'b1;
      set_exp(16'h0000);
      repeat (12) tick();

      chk("progress", handshakes >= 150, 1'b1);
      chk("wrap_seen", wseen, 4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
